// File: rtl/recip_share_sched.sv
// Shares one iterative reciprocal unit among NUM_REQ requesters: round-robin grant,
// single-launch control, zero-operand bypass and hung-unit timeout.
module recip_share_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 63,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_unit_start,
    output logic [DATA_W-1:0]         o_unit_operand,
    input  logic                      i_unit_done,
    input  logic [DATA_W-1:0]         i_unit_result,
    output logic                      o_rsp_valid,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_err,
    input  logic                      i_rsp_ready,
    output logic                      o_busy
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                start_q, start_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_operand;

    // Round-robin search starting at rr_ptr_q, wrapping at NUM_REQ.
    always_comb begin
        logic [ID_W:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            if (idx >= NUM_REQ_W) begin
                idx = idx - NUM_REQ_W;
            end
            if (!grant_found && i_req_valid[idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

    assign grant_operand = i_req_data[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        o_req_ready = '0;
        if (state_q == StIdle && grant_found) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        operand_d  = operand_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        start_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    id_d      = grant_idx;
                    operand_d = grant_operand;
                    if (grant_operand == '0) begin
                        rsp_data_d = '1;
                        rsp_err_d  = 1'b1;
                        state_d    = StResp;
                    end else begin
                        start_d = 1'b1;
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                // A completion arriving on the timeout cycle still counts as success.
                if (i_unit_done) begin
                    rsp_data_d = i_unit_result;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            operand_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            operand_q  <= operand_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            start_q    <= start_d;
        end
    end

    assign o_unit_start   = start_q;
    assign o_unit_operand = operand_q;
    assign o_rsp_valid    = (state_q == StResp);
    assign o_rsp_id       = id_q;
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_err      = rsp_err_q;
    assign o_busy         = (state_q != StIdle);

endmodule
